imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the core's instruction fetch interface.
- Serves the fetch address driven by the core with an asynchronous-read word lookup, so the IFU can latch IR on the same edge as PC.
- Contains a byte-serial program loader FSM that fills the memory over a valid/ready stream.
- Holds the core in reset while a load is in progress.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h00000000, byte address mapped to word 0; must be 4-byte aligned.
- NOP_WORD, 32'h00000013, word returned for invalid fetches (ADDI x0,x0,0).

Ports:
- clock_in  in  1  single clock; all state updates on the rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- fetch_addr_in  in  32  byte address from core (ins_mem_addr_out).
- fetch_data_out  out  32  instruction word to core (ins_mem_data_in).
- load_start_in  in  1  start a program load; sampled only in IDLE.
- load_base_in  in  32  byte address of the first word to load.
- load_len_in  in  16  number of 32-bit words to load.
- load_byte_in  in  8  stream byte.
- load_valid_in  in  1  stream byte valid.
- load_ready_out  out  1  responder accepts a byte this cycle.
- load_busy_out  out  1  high in LOAD and DONE.
- load_done_out  out  1  one-cycle pulse when the last word is written.
- load_error_out  out  1  sticky flag: last start request was rejected.
- core_reset_out  out  1  active-high reset to the core.

Behaviour:
- Reset (reset_in=0, async):
  - FSM goes to IDLE.
  - load_ready_out=0, load_busy_out=0, load_done_out=0, load_error_out=0.
  - Byte counter, word counter and assembler cleared.
  - core_reset_out=1, combinationally, for as long as reset_in=0.
  - Memory array is not cleared; contents survive reset.
- Fetch path (combinational, zero latency):
  - Word index = (fetch_addr_in - BASE_ADDR) >> 2.
  - fetch_data_out = mem[index] when fetch_addr_in[1:0]==0 and index < 2**ADDR_WIDTH.
  - Otherwise (misaligned, below BASE_ADDR via wrap, beyond depth) fetch_data_out = NOP_WORD.
  - fetch_data_out = NOP_WORD whenever load_busy_out=1.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_ready_out=0, core_reset_out=0.
  - On load_start_in=1, the request is valid when all of the following hold:
    - load_len_in != 0
    - load_base_in[1:0]==0
    - load_base_in >= BASE_ADDR
    - start index + load_len_in <= 2**ADDR_WIDTH (computed at 17+ bits, no wrap)
  - Valid request: latch the start word index and remaining = load_len_in, clear byte counter and load_error_out, go to LOAD.
  - Invalid request: set load_error_out=1 and stay in IDLE.
- LOAD:
  - load_ready_out=1, load_busy_out=1, core_reset_out=1.
  - A byte is accepted on each cycle with load_valid_in & load_ready_out.
  - Bytes assemble little-endian: byte 0 goes to [7:0], byte 3 to [31:24].
  - On acceptance of byte 3, write the assembled word to mem[index] at that edge, index+1, remaining-1, byte counter back to 0.
  - If remaining was 1 at that write, go to DONE.
  - Cycles with load_valid_in=0 are stalls: no state change.
  - load_start_in is ignored.
- DONE (exactly 1 cycle):
  - load_done_out=1, load_busy_out=1, core_reset_out=1, load_ready_out=0.
  - Next state is IDLE, where core_reset_out drops and the core restarts at its reset PC.
- Reset mid-load:
  - Partial word is discarded.
  - Words already written remain.
  - FSM returns to IDLE; no done pulse.
- Writes occur only in LOAD; the fetch port never writes.
- All counters are sized so they cannot overflow: byte counter 2 bits, remaining 16 bits, index ADDR_WIDTH+1 bits.

Test Plan:
- Reset, then fetch_addr_in=32'h4 with memory preloaded 32'hDEADBEEF at word 1 -> fetch_data_out=32'hDEADBEEF combinationally; fetch_addr_in=32'h6 -> 32'h00000013.
- Start base=0, len=2; stream bytes 13 00 00 00 93 00 10 00 with valid held high -> load_ready_out=1 for 8 cycles, then load_done_out pulses 1 cycle. Afterwards mem[0]=32'h00000013, mem[1]=32'h00100093, and core_reset_out falls the cycle after DONE.
- Same load with load_valid_in toggling every other cycle -> identical memory contents; done pulse arrives after 16 LOAD cycles; fetch_data_out=NOP throughout busy.
- Start len=0, then base=32'h2, then base=32'hFFC with len=2 (ADDR_WIDTH=10) -> each rejected: load_error_out=1, FSM stays IDLE, core_reset_out=0. A following valid start clears load_error_out.
- Assert reset_in=0 after 6 accepted bytes of a len=2 load -> core_reset_out=1 immediately, mem[0] holds the first word, mem[1] unchanged, no load_done_out, FSM IDLE after release.
- Pulse load_start_in during LOAD with different base/len -> ignored: the original load completes at the original addresses.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-latency fetch port plus a byte-serial
// program loader that holds the core in reset while it fills the array.
module imem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [31:0] fetch_addr_in,
  output logic [31:0] fetch_data_out,
  input  logic        load_start_in,
  input  logic [31:0] load_base_in,
  input  logic [15:0] load_len_in,
  input  logic [7:0]  load_byte_in,
  input  logic        load_valid_in,
  output logic        load_ready_out,
  output logic        load_busy_out,
  output logic        load_done_out,
  output logic        load_error_out,
  output logic        core_reset_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state;
  logic [31:0]         r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_idx;
  logic [15:0]         r_rem;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_asm;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic [31:0] w_off;
  logic        w_fetch_ok;
  logic [31:0] w_soff;
  logic [32:0] w_end;
  logic        w_start_ok;
  logic        w_accept;
  logic        w_we;

  // Fetch: base-relative word lookup; anything unmapped or during a load reads as NOP.
  assign w_off          = fetch_addr_in - BASE_ADDR;
  assign w_fetch_ok     = (w_off[1:0] == 2'b00) && (w_off[31:ADDR_WIDTH+2] == '0) && !r_busy;
  assign fetch_data_out = w_fetch_ok ? r_mem[w_off[ADDR_WIDTH+1:2]] : NOP_WORD;

  // End index is formed at 33 bits so a large base plus length cannot wrap into range.
  assign w_soff     = load_base_in - BASE_ADDR;
  assign w_end      = {3'b000, w_soff[31:2]} + {17'd0, load_len_in};
  assign w_start_ok = (load_len_in != 16'd0) && (w_soff[1:0] == 2'b00) &&
                      (load_base_in >= BASE_ADDR) && (w_end <= (33'd1 << ADDR_WIDTH));

  assign w_accept = r_ready && load_valid_in;
  assign w_we     = w_accept && (r_bcnt == 2'd3) && !r_idx[ADDR_WIDTH];

  assign load_ready_out = r_ready;
  assign load_busy_out  = r_busy;
  assign load_done_out  = r_done;
  assign load_error_out = r_error;
  assign core_reset_out = !reset_in || r_busy;

  // Array has no reset so a loaded program survives a core reset.
  always_ff @(posedge clock_in) begin
    if (w_we) r_mem[r_idx[ADDR_WIDTH-1:0]] <= {load_byte_in, r_asm};
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
      r_bcnt  <= '0;
      r_asm   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start_in) begin
            if (w_start_ok) begin
              r_state <= S_LOAD;
              r_idx   <= {1'b0, w_soff[ADDR_WIDTH+1:2]};
              r_rem   <= load_len_in;
              r_bcnt  <= '0;
              r_asm   <= '0;
              r_error <= 1'b0;
              r_ready <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_bcnt == 2'd3) begin
              r_idx  <= r_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
              r_rem  <= r_rem - 16'd1;
              r_bcnt <= '0;
              if (r_rem == 16'd1) begin
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              case (r_bcnt)
                2'd0:    r_asm[7:0]   <= load_byte_in;
                2'd1:    r_asm[15:8]  <= load_byte_in;
                default: r_asm[23:16] <= load_byte_in;
              endcase
              r_bcnt <= r_bcnt + 2'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: loads, stalls, rejected starts,
// reset mid-load and ignored mid-load start requests.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [31:0] fetch_data;
  logic        load_start = 1'b0;
  logic [31:0] load_base = '0;
  logic [15:0] load_len = '0;
  logic [7:0]  load_byte = '0;
  logic        load_valid = 1'b0;
  logic        load_ready, load_busy, load_done, load_error, core_reset;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] stream [0:7];
  int lc, rc, nopbad;

  imem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .NOP_WORD(NOP)) dut (
    .clock_in       (clk),
    .reset_in       (rst_n),
    .fetch_addr_in  (fetch_addr),
    .fetch_data_out (fetch_data),
    .load_start_in  (load_start),
    .load_base_in   (load_base),
    .load_len_in    (load_len),
    .load_byte_in   (load_byte),
    .load_valid_in  (load_valid),
    .load_ready_out (load_ready),
    .load_busy_out  (load_busy),
    .load_done_out  (load_done),
    .load_error_out (load_error),
    .core_reset_out (core_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    fetch_addr = addr;
    @(negedge clk);
    check(tag, fetch_data, exp);
  endtask

  // Streams stream[] into a load; toggle puts valid on odd cycles only.
  // A start request is pulsed on cycle mid_at (if >= 0) to prove it is ignored.
  task automatic run_load(input logic [31:0] base, input logic [15:0] len, input bit toggle,
                          input int mid_at, output int lcyc, output int rcyc, output int nbad);
    int  k;
    logic rdy;
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("enter_busy", 32'(load_busy), 32'd1);
    lcyc = 0; rcyc = 0; nbad = 0; k = 0;
    while (!load_done && lcyc < 200) begin
      load_valid = toggle ? (lcyc % 2 == 1) : 1'b1;
      load_byte  = stream[k % 8];
      if (lcyc == mid_at) begin
        load_start = 1'b1;
        load_base  = 32'h20;
        load_len   = 16'd3;
      end else begin
        load_start = 1'b0;
      end
      rdy = load_ready;
      if (rdy) rcyc++;
      if (fetch_data !== NOP) nbad++;
      tick();
      if (load_valid && rdy) k++;
      lcyc++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    check("done_pulse", 32'(load_done), 32'd1);
    check("done_busy", 32'(load_busy), 32'd1);
    check("done_ready", 32'(load_ready), 32'd0);
    check("done_core_rst", 32'(core_reset), 32'd1);
    check("done_fetch_nop", fetch_data, NOP);
    tick();
    check("idle_done", 32'(load_done), 32'd0);
    check("idle_busy", 32'(load_busy), 32'd0);
    check("idle_core_rst", 32'(core_reset), 32'd0);
  endtask

  task automatic reject(input string tag, input logic [31:0] base, input logic [15:0] len);
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check({tag, "_err"}, 32'(load_error), 32'd1);
    check({tag, "_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_ready"}, 32'(load_ready), 32'd0);
    check({tag, "_core_rst"}, 32'(core_reset), 32'd0);
    tick();
    check({tag, "_still_idle"}, 32'(load_busy), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_core_rst", 32'(core_reset), 32'd1);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_core_rst", 32'(core_reset), 32'd0);

    // Preload DEADBEEF at word 1, then fetch aligned and misaligned.
    stream = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(32'h4, 16'd1, 1'b0, -1, lc, rc, nopbad);
    check("pre_cycles", 32'(lc), 32'd4);
    fetch_chk("fetch_w1", 32'h4, 32'hDEADBEEF);
    fetch_chk("fetch_misaligned", 32'h6, NOP);
    tick();

    // Two-word load, valid held high.
    stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(32'h0, 16'd2, 1'b0, -1, lc, rc, nopbad);
    check("l2_cycles", 32'(lc), 32'd8);
    check("l2_ready_cycles", 32'(rc), 32'd8);
    check("l2_nop_busy", 32'(nopbad), 32'd0);
    fetch_chk("l2_w0", 32'h0, 32'h00000013);
    fetch_chk("l2_w1", 32'h4, 32'h00100093);
    fetch_chk("fetch_beyond", 32'h1000, NOP);
    tick();

    // Same data with stalls on every other cycle, placed at words 2..3.
    run_load(32'h8, 16'd2, 1'b1, -1, lc, rc, nopbad);
    check("stall_cycles", 32'(lc), 32'd16);
    check("stall_nop_busy", 32'(nopbad), 32'd0);
    fetch_chk("stall_w2", 32'h8, 32'h00000013);
    fetch_chk("stall_w3", 32'hC, 32'h00100093);
    tick();

    // Rejected starts, then a valid one at the very top of the array.
    reject("rej_len0", 32'h0, 16'd0);
    reject("rej_misal", 32'h2, 16'd1);
    reject("rej_overrun", 32'hFFC, 16'd2);
    stream = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    run_load(32'hFF8, 16'd2, 1'b0, -1, lc, rc, nopbad);
    check("top_err_cleared", 32'(load_error), 32'd0);
    fetch_chk("top_w1022", 32'hFF8, 32'hA4A3A2A1);
    fetch_chk("top_w1023", 32'hFFC, 32'hB4B3B2B1);
    tick();

    // Reset after 6 accepted bytes of a two-word load at word 0.
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    load_base  = 32'h0;
    load_len   = 16'd2;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_byte  = stream[i];
      tick();
      check("mid_no_done", 32'(load_done), 32'd0);
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_core_rst", 32'(core_reset), 32'd1);
    check("mid_rst_busy", 32'(load_busy), 32'd0);
    check("mid_rst_done", 32'(load_done), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_core_rst", 32'(core_reset), 32'd0);
    check("mid_rel_ready", 32'(load_ready), 32'd0);
    fetch_chk("mid_w0", 32'h0, 32'h44332211);
    fetch_chk("mid_w1_kept", 32'h4, 32'h00100093);
    tick();

    // Start pulse during LOAD must not retarget or lengthen the load.
    stream = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
    run_load(32'h10, 16'd1, 1'b0, 2, lc, rc, nopbad);
    check("ign_cycles", 32'(lc), 32'd4);
    fetch_chk("ign_w4", 32'h10, 32'hC3C2C1C0);
    fetch_chk("ign_w2_kept", 32'h8, 32'h00000013);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
